div_4bits_seq: RTL and testbench



---
 rtl/div_4bits_seq.sv | 105 ++++++++++
 tb/tb_div_4bits_seq.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/div_4bits_seq.sv
// Sequential restoring divider: one quotient bit per clock.
// Operands enter via start; results pulse out on done.
module div_4bits_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] d_q;
  logic [WIDTH:0]   r_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] quot_q;
  logic [WIDTH-1:0] rem_q;
  logic             dbz_q;

  logic [WIDTH:0]   shift_d;
  logic [WIDTH:0]   diff_d;
  logic [WIDTH:0]   r_d;
  logic [WIDTH-1:0] q_d;
  logic             accept;
  logic             last;

  // One restoring step: keep the difference only if it did not borrow.
  always_comb begin
    shift_d = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
    diff_d  = shift_d - {1'b0, d_q};
    r_d     = diff_d;
    q_d     = {q_q[WIDTH-2:0], 1'b1};
    if (diff_d[WIDTH]) begin
      r_d = shift_d;
      q_d = {q_q[WIDTH-2:0], 1'b0};
    end
  end

  assign accept = start && (state_q != RUN);
  assign last   = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      q_q     <= '0;
      d_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else if (accept) begin
      q_q   <= dividend;
      d_q   <= divisor;
      r_q   <= '0;
      cnt_q <= '0;
      dbz_q <= 1'b0;
      if (divisor == '0) begin
        state_q <= DONE;
        quot_q  <= '1;
        rem_q   <= dividend;
        dbz_q   <= 1'b1;
      end else begin
        state_q <= RUN;
      end
    end else begin
      case (state_q)
        RUN: begin
          r_q   <= r_d;
          q_q   <= q_d;
          cnt_q <= cnt_q + 1'b1;
          if (last) begin
            quot_q  <= q_d;
            rem_q   <= r_d[WIDTH-1:0];
            state_q <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = (state_q == RUN);
  assign done        = (state_q == DONE);
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_4bits_seq.sv
// Bench for div_4bits_seq: directed cases, exhaustive
// back-to-back sweep and random operations vs an arithmetic model.
module tb_div_4bits_seq;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] prev_q = '0;
  logic [W-1:0] prev_r = '0;

  div_4bits_seq #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [W-1:0] obs,
                      input logic [W-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division, all-ones quotient on zero divisor.
  function automatic logic [W-1:0] ref_q(input int a, input int b);
    if (b == 0) return '1;
    return W'(a / b);
  endfunction

  function automatic logic [W-1:0] ref_r(input int a, input int b);
    if (b == 0) return W'(a);
    return W'(a % b);
  endfunction

  task automatic start_op(input int a, input int b);
    start    = 1'b1;
    dividend = W'(a);
    divisor  = W'(b);
    tick();
    start = 1'b0;
  endtask

  // Called right after the accepting edge; follows the op to its done.
  task automatic finish_check(input int a, input int b);
    logic [W-1:0] eq;
    logic [W-1:0] er;
    eq = ref_q(a, b);
    er = ref_r(a, b);
    if (b != 0) begin
      for (int i = 0; i < W; i++) begin
        chk1("run_busy", busy, 1'b1);
        chk1("run_done", done, 1'b0);
        chkw("run_hold_q", quotient, prev_q);
        chkw("run_hold_r", remainder, prev_r);
        if (i < W - 1) tick();
      end
      tick();
    end
    chk1("done", done, 1'b1);
    chk1("done_busy", busy, 1'b0);
    chkw("quotient", quotient, eq);
    chkw("remainder", remainder, er);
    chk1("dbz", div_by_zero, b == 0);
    if (b != 0) begin
      n_tests++;
      assert ((int'(quotient) * b + int'(remainder) == a)
              && (int'(remainder) < b)) else begin
        n_fail++;
        $error("FAIL invariant: got q=%0d r=%0d for %0d/%0d",
               quotient, remainder, a, b);
      end
    end
    prev_q = eq;
    prev_r = er;
  endtask

  task automatic op(input int a, input int b);
    start_op(a, b);
    finish_check(a, b);
    tick();
    chk1("idle_done", done, 1'b0);
  endtask

  initial begin
    int a;
    int b;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    tick();
    tick();
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chkw("rst_q", quotient, '0);
    chkw("rst_r", remainder, '0);
    chk1("rst_dbz", div_by_zero, 1'b0);
    rst = 1'b0;
    tick();

    op(13, 3);
    op(15, 1);
    op(0, 7);
    op(5, 9);
    op(9, 0);

    // Start while busy is ignored; start held in done is accepted.
    start_op(13, 3);
    tick();
    start_op(6, 2);
    chk1("ign_busy", busy, 1'b1);
    tick();
    tick();
    chk1("ign_done", done, 1'b1);
    chkw("ign_q", quotient, 4'd4);
    chkw("ign_r", remainder, 4'd1);
    prev_q = 4'd4;
    prev_r = 4'd1;
    start_op(6, 2);
    chk1("b2b_done_fall", done, 1'b0);
    finish_check(6, 2);
    tick();

    // Reset mid-run aborts without a done pulse.
    start_op(14, 3);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk1("mid_rst_busy", busy, 1'b0);
    chk1("mid_rst_done", done, 1'b0);
    chkw("mid_rst_q", quotient, '0);
    chkw("mid_rst_r", remainder, '0);
    chk1("mid_rst_dbz", div_by_zero, 1'b0);
    for (int i = 0; i < W + 2; i++) begin
      chk1("no_done_after_rst", done, 1'b0);
      tick();
    end
    prev_q = '0;
    prev_r = '0;
    op(14, 3);

    // rst beats start on the same edge.
    rst      = 1'b1;
    start    = 1'b1;
    dividend = 4'd7;
    divisor  = 4'd2;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    chk1("rst_wins_busy", busy, 1'b0);
    chkw("rst_wins_q", quotient, '0);
    prev_q = '0;
    prev_r = '0;
    tick();

    // Exhaustive sweep, each new op accepted during the previous done.
    for (int i = 0; i < (1 << W); i++) begin
      for (int j = 0; j < (1 << W); j++) begin
        start_op(i, j);
        finish_check(i, j);
      end
    end
    tick();
    chk1("sweep_end_done", done, 1'b0);

    // Random operations with random idle gaps.
    for (int k = 0; k < 60; k++) begin
      a = int'($urandom_range((1 << W) - 1, 0));
      b = int'($urandom_range((1 << W) - 1, 0));
      start_op(a, b);
      finish_check(a, b);
      if ($urandom_range(1, 0) == 1) begin
        tick();
        chk1("rand_idle_done", done, 1'b0);
        for (int g = 0; g < int'($urandom_range(2, 0)); g++) tick();
      end
    end
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
